// File: rtl/arm_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_dec_pkg
// Purpose  : Shared definitions for the A64 decode stage: opcode match
//            constants, field widths, the ALU operation encoding and the
//            decoded bundle carried by the id_stage pipeline register.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package arm_dec_pkg;

  localparam int INSTR_W   = 32;
  localparam int REG_IDX_W = 5;
  localparam int IMM_W     = 64;

  // Opcode match values, compared against the leading bits of the word.
  localparam logic [10:0] OPC_ADD_R = 11'b10001011000;
  localparam logic [10:0] OPC_SUB_R = 11'b11001011000;
  localparam logic [10:0] OPC_AND_R = 11'b10001010000;
  localparam logic [10:0] OPC_ORR_R = 11'b10101010000;
  localparam logic [9:0]  OPC_ADD_I = 10'b1001000100;
  localparam logic [9:0]  OPC_SUB_I = 10'b1101000100;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
  localparam logic [5:0]  OPC_B     = 6'b000101;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [IMM_W-1:0]     imm;
    alu_op_e              alu_op;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 alu_src_imm;
    logic                 cond_branch;
    logic                 uncond_branch;
    logic                 illegal;
  } dec_bundle_t;

  // Bundle for an unsupported word: every index, flag and the ALU op are 0.
  function automatic dec_bundle_t illegal_bundle();
    dec_bundle_t b;
    b         = '0;
    b.illegal = 1'b1;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_if
// Purpose  : Fetch-side and execute-side handshake plus decoded bundle of the
//            decode stage.
// Ports    : master = environment (drives in_*, flush, out_ready)
//            slave  = id_stage    (drives in_ready, out_* and bundle fields)
// Revision : 1.0  initial release
// ============================================================================
interface id_stage_if #(
  parameter int PC_W = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      rd_addr_1;
  logic [4:0]      rd_addr_2;
  logic [4:0]      wr_addr;
  logic [63:0]     imm;
  logic [2:0]      alu_op;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            alu_src_imm;
  logic            cond_branch;
  logic            uncond_branch;
  logic            illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rd_addr_1, rd_addr_2, wr_addr, imm,
           alu_op, reg_write, mem_read, mem_write, alu_src_imm, cond_branch,
           uncond_branch, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rd_addr_1, rd_addr_2, wr_addr, imm,
           alu_op, reg_write, mem_read, mem_write, alu_src_imm, cond_branch,
           uncond_branch, illegal
  );
endinterface
`default_nettype wire

// File: rtl/id_decoder.sv
`default_nettype none
// ============================================================================
// Module   : id_decoder
// Purpose  : Purely combinational A64 subset decoder, 32-bit word to
//            dec_bundle_t.
// Ports    : instr_i  - instruction word
//            dec_o    - decoded indices, immediate, ALU op and flags
// Revision : 1.0  initial release
// ============================================================================
module id_decoder
  import arm_dec_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output dec_bundle_t        dec_o
);

  logic [4:0] f_rd;
  logic [4:0] f_rn;
  logic [4:0] f_rm;

  assign f_rd = instr_i[4:0];
  assign f_rn = instr_i[9:5];
  assign f_rm = instr_i[20:16];

  always_comb begin
    dec_o = '0;
    if ((instr_i[31:21] == OPC_ADD_R || instr_i[31:21] == OPC_SUB_R ||
         instr_i[31:21] == OPC_AND_R || instr_i[31:21] == OPC_ORR_R) &&
        instr_i[15:10] == 6'd0) begin
      // Register forms; shifted operands (imm6 != 0) fall through to illegal.
      dec_o.rs1       = f_rn;
      dec_o.rs2       = f_rm;
      dec_o.rd        = f_rd;
      dec_o.reg_write = 1'b1;
      case (instr_i[31:21])
        OPC_SUB_R: dec_o.alu_op = ALU_SUB;
        OPC_AND_R: dec_o.alu_op = ALU_AND;
        OPC_ORR_R: dec_o.alu_op = ALU_ORR;
        default:   dec_o.alu_op = ALU_ADD;
      endcase
    end else if (instr_i[31:22] == OPC_ADD_I || instr_i[31:22] == OPC_SUB_I) begin
      dec_o.rs1         = f_rn;
      dec_o.rd          = f_rd;
      dec_o.imm         = {52'd0, instr_i[21:10]};
      dec_o.alu_op      = (instr_i[31:22] == OPC_SUB_I) ? ALU_SUB : ALU_ADD;
      dec_o.alu_src_imm = 1'b1;
      dec_o.reg_write   = 1'b1;
    end else if ((instr_i[31:21] == OPC_LDUR || instr_i[31:21] == OPC_STUR) &&
                 instr_i[11:10] == 2'b00) begin
      dec_o.rs1         = f_rn;
      dec_o.imm         = {{55{instr_i[20]}}, instr_i[20:12]};
      dec_o.alu_op      = ALU_ADD;
      dec_o.alu_src_imm = 1'b1;
      if (instr_i[31:21] == OPC_LDUR) begin
        dec_o.rd        = f_rd;
        dec_o.mem_read  = 1'b1;
        dec_o.reg_write = 1'b1;
      end else begin
        // Store data register travels on the second read port.
        dec_o.rs2       = f_rd;
        dec_o.mem_write = 1'b1;
      end
    end else if (instr_i[31:24] == OPC_CBZ) begin
      // Rt is tested against zero, so it is read on the second port and
      // passed straight through the ALU.
      dec_o.rs2         = f_rd;
      dec_o.imm         = {{43{instr_i[23]}}, instr_i[23:5], 2'b00};
      dec_o.alu_op      = ALU_PASSB;
      dec_o.cond_branch = 1'b1;
    end else if (instr_i[31:26] == OPC_B) begin
      dec_o.imm           = {{36{instr_i[25]}}, instr_i[25:0], 2'b00};
      dec_o.uncond_branch = 1'b1;
    end else begin
      dec_o = illegal_bundle();
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : A64 instruction-decode pipeline stage. Accepts fetched words on
//            a valid/ready handshake, decodes them and holds the result in a
//            single pipeline register feeding reg_file and execute. An
//            unsupported word halts the stage until flush or reset.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            stage_if  - id_stage_if.slave: fetch handshake, flush, execute
//                        handshake, register indices, immediate and flags
// Revision : 1.0  initial release
// ============================================================================
module id_stage #(
  parameter int PC_W = 64
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  stage_if
);
  import arm_dec_pkg::*;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          state_q;
  logic            out_valid_q;
  logic [PC_W-1:0] pc_q;
  dec_bundle_t     dec_q;
  dec_bundle_t     dec_d;
  logic            in_ready_w;
  logic            accept_w;

  id_decoder u_decoder (
    .instr_i (stage_if.in_instr),
    .dec_o   (dec_d)
  );

  // in_ready depends only on state, the held valid and out_ready; never on
  // in_valid. During flush it reads high, but the word is dropped.
  assign in_ready_w = stage_if.flush |
                      ((state_q == ST_RUN) & (~out_valid_q | stage_if.out_ready));
  assign accept_w   = stage_if.in_valid & in_ready_w & ~stage_if.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      dec_q       <= '0;
    end else if (stage_if.flush) begin
      // Flush beats both accept and HALT entry.
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
    end else if (accept_w) begin
      out_valid_q <= 1'b1;
      pc_q        <= stage_if.in_pc;
      dec_q       <= dec_d;
      if (dec_d.illegal) begin
        state_q <= ST_HALT;
      end
    end else if (stage_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign stage_if.in_ready      = in_ready_w;
  assign stage_if.out_valid     = out_valid_q;
  assign stage_if.out_pc        = pc_q;
  assign stage_if.rd_addr_1     = dec_q.rs1;
  assign stage_if.rd_addr_2     = dec_q.rs2;
  assign stage_if.wr_addr       = dec_q.rd;
  assign stage_if.imm           = dec_q.imm;
  assign stage_if.alu_op        = dec_q.alu_op;
  assign stage_if.reg_write     = dec_q.reg_write;
  assign stage_if.mem_read      = dec_q.mem_read;
  assign stage_if.mem_write     = dec_q.mem_write;
  assign stage_if.alu_src_imm   = dec_q.alu_src_imm;
  assign stage_if.cond_branch   = dec_q.cond_branch;
  assign stage_if.uncond_branch = dec_q.uncond_branch;
  assign stage_if.illegal       = dec_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage: directed test-plan sequences
//            followed by randomized traffic, checked by a scoreboard against
//            an arithmetic reference decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_if #(.PC_W(64)) bus ();

  id_stage #(.PC_W(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .stage_if (bus.slave)
  );

  // Flags: {reg_write, mem_read, mem_write, alu_src_imm, cond, uncond, illegal}
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [63:0] imm;
    logic [2:0]  op;
    logic [6:0]  fl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic m_valid = 1'b0, m_halt = 1'b0, exp_ready = 1'b1, exp_zero = 1'b0;
  logic mon_en  = 1'b0;
  logic p_rst = 1'b0, p_flush = 1'b0, p_acc = 1'b0, p_ill = 1'b0, p_ordy = 1'b0;

  // Reference decoder, from instruction-field arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t            e;
    longint unsigned u;
    longint          s;
    longint unsigned t11, t10, rd, rn, rm;
    e   = '0;
    e.pc = pc;
    u   = 64'(w);
    t11 = u >> 21;
    t10 = u >> 22;
    rd  = u % 32;
    rn  = (u >> 5) % 32;
    rm  = (u >> 16) % 32;
    if ((t11 == 'h458 || t11 == 'h658 || t11 == 'h450 || t11 == 'h550) &&
        ((u >> 10) % 64) == 0) begin
      e.r1 = 5'(rn); e.r2 = 5'(rm); e.wr = 5'(rd);
      e.op = (t11 == 'h458) ? 3'd0 : (t11 == 'h658) ? 3'd1 : (t11 == 'h450) ? 3'd2 : 3'd3;
      e.fl = 7'b1000000;
    end else if (t10 == 'h244 || t10 == 'h344) begin
      e.r1 = 5'(rn); e.wr = 5'(rd);
      e.imm = (u >> 10) % 4096;
      e.op = (t10 == 'h344) ? 3'd1 : 3'd0;
      e.fl = 7'b1001000;
    end else if ((t11 == 'h7C2 || t11 == 'h7C0) && ((u >> 10) % 4) == 0) begin
      s = longint'((u >> 12) % 512);
      if (s >= 256) s = s - 512;
      e.imm = 64'(s);
      e.r1  = 5'(rn);
      if (t11 == 'h7C2) begin
        e.wr = 5'(rd); e.fl = 7'b1101000;
      end else begin
        e.r2 = 5'(rd); e.fl = 7'b0011000;
      end
    end else if ((u >> 24) == 'hB4) begin
      s = longint'((u >> 5) % (64'd1 << 19));
      if (s >= (64'sd1 <<< 18)) s = s - (64'sd1 <<< 19);
      e.imm = 64'(s * 4);
      e.r2 = 5'(rd); e.op = 3'd4; e.fl = 7'b0000100;
    end else if ((u >> 26) == 5) begin
      s = longint'(u % (64'd1 << 26));
      if (s >= (64'sd1 <<< 25)) s = s - (64'sd1 <<< 26);
      e.imm = 64'(s * 4);
      e.fl = 7'b0000010;
    end else begin
      e.fl = 7'b0000001;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] r;
    logic [10:0] rops [4];
    int          k;
    rops = '{11'h458, 11'h658, 11'h450, 11'h550};
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0, 1, 2, 3: return {rops[k], r[20:16], 6'd0, r[9:0]};
      4:  return {r[30] ? 10'h344 : 10'h244, r[21:0]};
      5:  return {11'h7C2, r[20:12], 2'b00, r[9:0]};
      6:  return {11'h7C0, r[20:12], 2'b00, r[9:0]};
      7:  return {8'hB4, r[23:0]};
      8:  return {6'h05, r[25:0]};
      9:  return {rops[r[31:30]], r[20:0]};
      10: return {r[31] ? 11'h7C2 : 11'h7C0, r[20:0]};
      default: return r;
    endcase
  endfunction

  // One cycle: retire the previous edge in the model, then drive new inputs.
  task automatic step(input logic v, input logic [31:0] w, input logic [63:0] pc,
                      input logic ordy, input logic fl, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    if (p_rst) begin
      m_valid = 1'b0; m_halt = 1'b0; exp_zero = 1'b1; q.delete();
    end else if (p_flush) begin
      m_valid = 1'b0; m_halt = 1'b0;
    end else if (p_acc) begin
      m_valid = 1'b1; exp_zero = 1'b0;
      if (p_ill) m_halt = 1'b1;
    end else if (p_ordy) begin
      m_valid = 1'b0;
    end
    rst           = r;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    exp_ready = fl | (~m_halt & (~m_valid | ordy));
    p_rst   = r;
    p_flush = fl;
    p_ordy  = ordy;
    p_acc   = v & exp_ready & ~fl & ~r;
    p_ill   = 1'b0;
    if (p_acc) begin
      e = model(w, pc);
      p_ill = e.fl[0];
      q.push_back(e);
    end
  endtask

  function automatic exp_t actual();
    exp_t a;
    a.pc  = bus.out_pc;
    a.r1  = bus.rd_addr_1;
    a.r2  = bus.rd_addr_2;
    a.wr  = bus.wr_addr;
    a.imm = bus.imm;
    a.op  = bus.alu_op;
    a.fl  = {bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src_imm,
             bus.cond_branch, bus.uncond_branch, bus.illegal};
    return a;
  endfunction

  task automatic cmp_bundle(input string name, input exp_t exp);
    exp_t a;
    a = actual();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got pc=%h r1=%0d r2=%0d wr=%0d imm=%h op=%0d fl=%b expected pc=%h r1=%0d r2=%0d wr=%0d imm=%h op=%0d fl=%b",
               name, $time, a.pc, a.r1, a.r2, a.wr, a.imm, a.op, a.fl,
               exp.pc, exp.r1, exp.r2, exp.wr, exp.imm, exp.op, exp.fl);
    end
  endtask

  // Monitor: samples mid-cycle, compares against model and scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus.in_ready !== exp_ready) begin
        errors++;
        $display("FAIL in_ready t=%0t got %b expected %b", $time, bus.in_ready, exp_ready);
      end
      checks++;
      if (bus.out_valid !== m_valid) begin
        errors++;
        $display("FAIL out_valid t=%0t got %b expected %b", $time, bus.out_valid, m_valid);
      end
      if (m_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard t=%0t got empty queue expected an entry", $time);
        end else begin
          cmp_bundle("bundle", q[0]);
          if (bus.out_ready || bus.flush) void'(q.pop_front());
        end
      end else if (exp_zero) begin
        cmp_bundle("reset_zero", '0);
      end
    end
  end

  initial begin
    logic        v, ordy, fl, r;
    logic [31:0] w;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;

    // ADD X1,X2,X3
    step(1'b1, 32'h8B030041, 64'h1000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,        64'h0,    1'b1, 1'b0, 1'b0);
    // Back-to-back ADD imm, LDUR, CBZ, B
    step(1'b1, 32'h91001420, 64'h1004, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hF85F8062, 64'h1008, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hB4FFFFE4, 64'h100C, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h14000002, 64'h1010, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,        64'h0,    1'b1, 1'b0, 1'b0);
    // Backpressure for 3 cycles with a word waiting
    step(1'b1, 32'h8B030041, 64'h2000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h91001420, 64'h2004, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h91001420, 64'h2004, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,        64'h0,    1'b1, 1'b0, 1'b0);
    // Illegal word, HALT, consume, flush with a discarded word
    step(1'b1, 32'h00000000, 64'h3000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h8B030041, 64'h3004, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h8B030041, 64'h3004, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h91001420, 64'h3008, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0,        64'h0,    1'b1, 1'b0, 1'b0);
    // Reset while HALTed with a valid bundle held
    step(1'b1, 32'h00000000, 64'h4000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,        64'h0,    1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0,        64'h0,    1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,        64'h0,    1'b1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = m_halt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      r    = ($urandom_range(0, 99) == 0);
      w    = gen_word();
      step(v, w, {$urandom, $urandom}, ordy, fl, r);
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode pipeline stage for the 64-bit ARM core, directly upstream of `reg_file`. It accepts fetched A64 instruction words over a valid/ready handshake and decodes the supported subset. Decoded results go into one pipeline register that drives the register-file read indices and a control/immediate bundle for the execute stage. An unsupported encoding halts the stage until a flush.

## Interface
Parameters:
- `PC_W`, default 64: program-counter width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: fetch presents `in_instr` and `in_pc`.
- `in_ready`, out, 1: stage accepts this cycle.
- `in_instr`, in, 32: A64 instruction word.
- `in_pc`, in, PC_W: address of `in_instr`.
- `flush`, in, 1: squash held and incoming instruction and clear HALT.
- `out_valid`, out, 1: decoded bundle valid.
- `out_ready`, in, 1: execute consumes the bundle this cycle.
- `out_pc`, out, PC_W: PC of the decoded instruction.
- `rd_addr_1`, out, 5: first source index (Rn); goes to `reg_file`.
- `rd_addr_2`, out, 5: second source index (Rm, or Rt for STUR/CBZ).
- `wr_addr`, out, 5: destination index (Rd/Rt).
- `imm`, out, 64: extended immediate.
- `alu_op`, out, 3: ADD=0, SUB=1, AND=2, ORR=3, PASSB=4.
- `reg_write`, `mem_read`, `mem_write`, `alu_src_imm`, `cond_branch`, `uncond_branch`, out, 1 each: control flags.
- `illegal`, out, 1: bundle carries an unsupported encoding.

## Operation
Supported encodings (64-bit forms only, shift=00):
- ADD/SUB/AND/ORR register: bits[31:21] = `10001011000` / `11001011000` / `10001010000` / `10101010000`.
  - `reg_write`=1.
  - imm6 ≠ 0 is illegal.
- ADD/SUB immediate: bits[31:22] = `1001000100` / `1101000100`.
  - imm = zero-extended imm12.
  - `alu_src_imm`=1, `reg_write`=1.
- LDUR/STUR: bits[31:21] = `11111000010` / `11111000000`, bits[11:10] = `00`.
  - imm = sign-extended imm9; ADD; `alu_src_imm`=1.
  - LDUR: `mem_read`=1, `reg_write`=1.
  - STUR: `mem_write`=1.
- CBZ: bits[31:24] = `10110100`.
  - imm = sign-extended {imm19, 2'b00}; `alu_op`=PASSB; `cond_branch`=1.
- B: bits[31:26] = `000101`.
  - imm = sign-extended {imm26, 2'b00}; `uncond_branch`=1.
- Any other word: `illegal`=1, and every other control flag and `alu_op` is 0.

Register fields:
- Unused index fields are 0.
- Index 31 passes unmodified; the register file resolves XZR/SP.

State machine, RUN and HALT:
- RUN:
  - `in_ready` = !`out_valid` | `out_ready`.
  - An accepted instruction loads the pipeline register and sets `out_valid`=1.
  - If `out_ready` is high with no accept, `out_valid` clears.
  - An accepted illegal word moves to HALT.
- HALT:
  - `in_ready`=0.
  - The illegal bundle is still presented and can be consumed; `out_valid` then clears.
  - Leaves only on `flush` or `rst`, to RUN.
- `flush`, in either state:
  - Next edge: `out_valid`=0, state RUN.
  - `in_ready`=1 during flush, but the presented word is discarded.
  - Flush has priority over accept and over HALT entry.

## Timing
- Latency 1 cycle: a word accepted at edge N appears with `out_valid`=1 after edge N.
- Full throughput (one per cycle) while `out_ready`=1.
- Backpressure: with `out_valid`=1 and `out_ready`=0, all outputs are held stable and `in_ready`=0 (no combinational path from `in_valid` to `in_ready`).
- Simultaneous consume and accept: the register is replaced in the same edge, so there is no bubble.
- Reset (synchronous, also mid-operation): after the edge, state RUN, `out_valid`=0, all bundle outputs 0, `in_ready`=1.
- `rd_addr_1`/`rd_addr_2` are registered. `reg_file` reads during the cycle the bundle is valid.

## Structure
- Package `arm_dec_pkg`:
  - opcode match constants and widths;
  - `alu_op` enum;
  - packed struct `dec_bundle_t` (indices, imm, `alu_op`, flags).
- Sub-module `id_decoder`: purely combinational, 32-bit word to `dec_bundle_t`.
- `id_stage` holds the handshake, the RUN/HALT FSM, and the pipeline register.

## Test plan
- ADD X1,X2,X3 (`0x8B030041`) accepted, then next cycle:
  - `rd_addr_1`=2, `rd_addr_2`=3, `wr_addr`=1, `alu_op`=0, `reg_write`=1, `alu_src_imm`=0.
- Back-to-back ADD X0,X1,#5 (`0x91001420`) then LDUR X2,[X3,#-8] (`0xF85F8062`), `out_ready`=1:
  - consecutive bundles, imm=5 then `0xFFFF_FFFF_FFFF_FFF8`; `mem_read`=1 on the second.
- CBZ X4,-4 (`0xB4FFFFE4`) and B +8 (`0x14000002`):
  - CBZ: imm=`0xFFFF_FFFF_FFFF_FFFC`, `rd_addr_2`=4, `cond_branch`=1, `reg_write`=0.
  - B: imm=8, `uncond_branch`=1.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1:
  - `in_ready`=0 and outputs stable throughout; the next word is accepted on the edge `out_ready` returns high.
- Word `0x00000000`:
  - `illegal`=1, FSM to HALT, `in_ready`=0 even after consume.
  - `flush` pulse returns `in_ready`=1; the word presented during the flush is not emitted.
- Assert `rst` while `out_valid`=1 and in HALT:
  - next cycle `out_valid`=0, all outputs 0, `in_ready`=1.
